// File: rtl/puf_chal_ctrl.sv
// Runs one PUF challenge/response transaction: accept a challenge, pulse start, wait for done
// or timeout, then stream the response MSB byte first over valid/ready.
module puf_chal_ctrl #(
   parameter int CHAL_WIDTH = 64,
   parameter int RESP_WIDTH = 32,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHAL_WIDTH-1:0] s_chal_data,
   input  logic                  s_chal_valid,
   output logic                  s_chal_ready,
   output logic [CHAL_WIDTH-1:0] puf_challenge,
   output logic                  puf_start,
   input  logic                  puf_done,
   input  logic [RESP_WIDTH-1:0] puf_response,
   output logic [7:0]            m_tx_data,
   output logic                  m_tx_valid,
   input  logic                  m_tx_ready,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int RESP_BYTES = RESP_WIDTH / 8;
   localparam int WCW        = $clog2(TIMEOUT);
   localparam int BCW        = $clog2(RESP_BYTES) + 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, SEND} state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  armed;
   logic [WCW-1:0]        wait_cnt;
   logic [BCW-1:0]        byte_cnt;
   logic [RESP_WIDTH-1:0] resp;
   logic                  accept;
   logic                  last_byte;
   logic                  wait_expired;

   assign s_chal_ready = (state == IDLE) && armed;
   assign accept       = s_chal_valid && s_chal_ready;
   assign last_byte    = (byte_cnt == BCW'(RESP_BYTES - 1));
   assign wait_expired = (wait_cnt == WCW'(TIMEOUT - 1));
   assign m_tx_data    = resp[RESP_WIDTH-1 -: 8];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      puf_start  = 1'b0;
      m_tx_valid = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (accept) state_nxt = LAUNCH;
         end
         LAUNCH: begin
            puf_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (puf_done || wait_expired) state_nxt = SEND;
         end
         SEND: begin
            m_tx_valid = 1'b1;
            if (m_tx_ready && last_byte) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         armed         <= 1'b0;
         puf_challenge <= '0;
         timeout_err   <= 1'b0;
         wait_cnt      <= '0;
         byte_cnt      <= '0;
         resp          <= '0;
      end else begin
         // valid is level-held by the source, so a new challenge needs a low cycle first
         if (!s_chal_valid) armed <= 1'b1;
         else if (accept)   armed <= 1'b0;

         case (state)
            IDLE: begin
               if (accept) begin
                  puf_challenge <= s_chal_data;
                  timeout_err   <= 1'b0;
               end
            end
            LAUNCH: wait_cnt <= '0;
            WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (puf_done) begin
                  resp <= puf_response;
               end else if (wait_expired) begin
                  resp        <= '1;
                  timeout_err <= 1'b1;
               end
            end
            SEND: begin
               if (m_tx_ready) begin
                  resp <= resp << 8;
                  if (last_byte) byte_cnt <= '0;
                  else           byte_cnt <= byte_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
